adc_sample_filter: RTL and testbench



---
 rtl/adc_sample_filter.sv | 83 ++++++++
 tb/tb_adc_sample_filter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_filter.sv
// adc_sample_filter: frame-rate ADC sampler with boxcar moving average; define ADC_FILT_PEAK_EN to build peak hold
module adc_sample_filter #(
  parameter int DATA_W   = 8,
  parameter int AVG_LOG2 = 3,
  parameter int DIV      = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] adc_data_i,
  input  logic              filt_clr_i,
  output logic [DATA_W-1:0] filt_data_o,
  output logic              filt_vld_o,
  output logic              filt_full_o,
  output logic [DATA_W-1:0] peak_max_o,
  output logic [DATA_W-1:0] peak_min_o
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW = DATA_W + AVG_LOG2;
  localparam int TW = $clog2(DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [AVG_LOG2:0] FILL_MAX = (AVG_LOG2 + 1)'(DEPTH);
  logic [TW-1:0] tick_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [AVG_LOG2:0] fill_cnt;
  logic [SW-1:0] sum;
  logic [SW-1:0] sum_next;
  logic sample_stb;
  // frame tick and running-sum update: new sample in, oldest (zero while filling) out
  always_comb begin
    sample_stb = tick_cnt == TICK_LAST;
    sum_next = sum + SW'(adc_data_i) - SW'(mem[wr_ptr]);
  end
  assign filt_full_o = fill_cnt == FILL_MAX;
  // tick counter, circular window, running sum and filtered output
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_cnt <= '0;
      mem <= '{default: '0};
      wr_ptr <= '0;
      fill_cnt <= '0;
      sum <= '0;
      filt_data_o <= '0;
      filt_vld_o <= 1'b0;
    end else if (filt_clr_i) begin
      tick_cnt <= '0;
      mem <= '{default: '0};
      wr_ptr <= '0;
      fill_cnt <= '0;
      sum <= '0;
      filt_data_o <= '0;
      filt_vld_o <= 1'b0;
    end else begin
      tick_cnt <= sample_stb ? '0 : tick_cnt + 1'b1;
      filt_vld_o <= sample_stb;
      if (sample_stb) begin
        mem[wr_ptr] <= adc_data_i;
        wr_ptr <= wr_ptr + 1'b1;
        sum <= sum_next;
        filt_data_o <= sum_next[SW-1:AVG_LOG2];
        fill_cnt <= filt_full_o ? fill_cnt : fill_cnt + 1'b1;
      end
    end
  end
`ifdef ADC_FILT_PEAK_EN
  // running extremes of every captured sample since reset or clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      peak_max_o <= '0;
      peak_min_o <= '1;
    end else if (filt_clr_i) begin
      peak_max_o <= '0;
      peak_min_o <= '1;
    end else if (sample_stb) begin
      peak_max_o <= adc_data_i > peak_max_o ? adc_data_i : peak_max_o;
      peak_min_o <= adc_data_i < peak_min_o ? adc_data_i : peak_min_o;
    end
  end
`else
  assign peak_max_o = '0;
  assign peak_min_o = '1;
`endif
endmodule

// File: tb/tb_adc_sample_filter.sv
// tb_adc_sample_filter: scoreboard bench for the frame-rate moving-average filter
module tb_adc_sample_filter;
  localparam int DW = 8;
  localparam int AL = 3;
  localparam int DV = 4;
`ifdef ADC_FILT_PEAK_EN
  localparam bit PEAK = 1'b1;
`else
  localparam bit PEAK = 1'b0;
`endif
  typedef struct {
    logic [7:0] d;
    logic       f;
    logic [7:0] mx;
    logic [7:0] mn;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic [7:0] adc = 8'd100;
  logic [7:0] fd, pmax, pmin;
  logic fv, ff;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int nsmp = 0;
  int last = -1;
  logic [7:0] mdl_max = 8'd0;
  logic [7:0] mdl_min = 8'hff;
  exp_t sb[$];

  adc_sample_filter #(.DATA_W(DW), .AVG_LOG2(AL), .DIV(DV)) dut (
    .clk_i(clk), .rst_i(rst), .adc_data_i(adc), .filt_clr_i(clr),
    .filt_data_o(fd), .filt_vld_o(fv), .filt_full_o(ff),
    .peak_max_o(pmax), .peak_min_o(pmin)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_reset();
    nsmp = 0;
    mdl_max = 8'd0;
    mdl_min = 8'hff;
    sb.delete();
  endtask

  task automatic push_exp(input logic [7:0] v, input logic [7:0] d);
    exp_t e;
    nsmp++;
    if (v > mdl_max) mdl_max = v;
    if (v < mdl_min) mdl_min = v;
    e.d = d;
    e.f = nsmp >= 8;
    e.mx = PEAK ? mdl_max : 8'd0;
    e.mn = PEAK ? mdl_min : 8'hff;
    sb.push_back(e);
  endtask

  task automatic wait_vld(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * DV && !ok; i++) begin
      @(negedge clk);
      ok = fv;
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_reset();
    last = cyc;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({fv, fd, ff, pmax, pmin} !== {1'b0, 8'd0, 1'b0, 8'd0, 8'hff}) begin
      fails++;
      $display("FAIL reset: vld=%b data=%0d full=%b max=%0d min=%0d, expected 0 0 0 0 255", fv, fd, ff, pmax, pmin);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    last = cyc;
  endtask

  task automatic test_ramp();
    int ramp [8] = '{12, 25, 37, 50, 62, 75, 87, 100};
    bit ok;
    exp_t e;
    for (int k = 1; k <= 16; k++) begin
      adc = 8'd100;
      push_exp(adc, k <= 8 ? 8'(ramp[k-1]) : 8'd100);
      wait_vld(ok);
      e = sb.pop_front();
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL ramp[%0d]: no filt_vld_o within %0d cycles", k, 3 * DV);
      end else begin
        if ({fd, ff, pmax, pmin} !== {e.d, e.f, e.mx, e.mn}) begin
          fails++;
          $display("FAIL ramp[%0d]: data=%0d full=%b max=%0d min=%0d, expected data=%0d full=%b max=%0d min=%0d", k, fd, ff, pmax, pmin, e.d, e.f, e.mx, e.mn);
        end
        tests++;
        if (cyc - last != DV) begin
          fails++;
          $display("FAIL ramp_spacing[%0d]: %0d cycles, expected %0d", k, cyc - last, DV);
        end
        last = cyc;
      end
    end
  endtask

  task automatic test_full_scale();
    bit ok;
    exp_t e;
    do_clear();
    for (int k = 1; k <= 16; k++) begin
      adc = 8'd255;
      push_exp(adc, 8'((255 * (k < 8 ? k : 8)) / 8));
      wait_vld(ok);
      e = sb.pop_front();
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL full_scale[%0d]: no filt_vld_o within %0d cycles", k, 3 * DV);
      end else if ({fd, ff, pmax, pmin} !== {e.d, e.f, e.mx, e.mn}) begin
        fails++;
        $display("FAIL full_scale[%0d]: data=%0d full=%b max=%0d min=%0d, expected data=%0d full=%b max=%0d min=%0d", k, fd, ff, pmax, pmin, e.d, e.f, e.mx, e.mn);
      end
    end
    tests++;
    if (dut.sum !== 11'd2040) begin
      fails++;
      $display("FAIL full_scale_sum: sum=%0d, expected 2040", dut.sum);
    end
  endtask

  task automatic test_step_down();
    bit ok;
    exp_t e;
    do_clear();
    for (int k = 1; k <= 16; k++) begin
      adc = k <= 8 ? 8'd200 : 8'd0;
      push_exp(adc, k <= 8 ? 8'(25 * k) : 8'(200 - 25 * (k - 8)));
      wait_vld(ok);
      e = sb.pop_front();
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL step_down[%0d]: no filt_vld_o within %0d cycles", k, 3 * DV);
      end else if ({fd, ff, pmax, pmin} !== {e.d, e.f, e.mx, e.mn}) begin
        fails++;
        $display("FAIL step_down[%0d]: data=%0d full=%b max=%0d min=%0d, expected data=%0d full=%b max=%0d min=%0d", k, fd, ff, pmax, pmin, e.d, e.f, e.mx, e.mn);
      end
    end
  endtask

  task automatic test_clear_collision();
    bit ok;
    exp_t e;
    int c0;
    adc = 8'd100;
    push_exp(adc, 8'd12);
    wait_vld(ok);
    e = sb.pop_front();
    tests++;
    if (!ok || {fd, ff, pmax, pmin} !== {e.d, e.f, e.mx, e.mn}) begin
      fails++;
      $display("FAIL pre_clear: vld=%b data=%0d full=%b max=%0d min=%0d, expected data=%0d full=%b max=%0d min=%0d", ok, fd, ff, pmax, pmin, e.d, e.f, e.mx, e.mn);
    end
    repeat (DV - 1) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    c0 = cyc;
    tests++;
    if ({fv, fd, ff, pmax, pmin} !== {1'b0, 8'd0, 1'b0, 8'd0, 8'hff}) begin
      fails++;
      $display("FAIL clear_collision: vld=%b data=%0d full=%b max=%0d min=%0d, expected 0 0 0 0 255", fv, fd, ff, pmax, pmin);
    end
    model_reset();
    push_exp(adc, 8'd12);
    wait_vld(ok);
    e = sb.pop_front();
    tests++;
    if (!ok || {fd, ff, pmax, pmin} !== {e.d, e.f, e.mx, e.mn}) begin
      fails++;
      $display("FAIL post_clear: vld=%b data=%0d full=%b max=%0d min=%0d, expected data=%0d full=%b max=%0d min=%0d", ok, fd, ff, pmax, pmin, e.d, e.f, e.mx, e.mn);
    end
    tests++;
    if (cyc - c0 != DV) begin
      fails++;
      $display("FAIL post_clear_latency: %0d cycles, expected %0d", cyc - c0, DV);
    end
    last = cyc;
  endtask

  task automatic test_peak();
    logic [7:0] vals [4] = '{8'd40, 8'd200, 8'd7, 8'd90};
    logic [7:0] avgs [4] = '{8'd5, 8'd30, 8'd30, 8'd42};
    bit ok;
    exp_t e;
    do_clear();
    for (int k = 0; k < 4; k++) begin
      adc = vals[k];
      push_exp(adc, avgs[k]);
      wait_vld(ok);
      e = sb.pop_front();
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL peak[%0d]: no filt_vld_o within %0d cycles", k, 3 * DV);
      end else if ({fd, ff, pmax, pmin} !== {e.d, e.f, e.mx, e.mn}) begin
        fails++;
        $display("FAIL peak[%0d]: data=%0d full=%b max=%0d min=%0d, expected data=%0d full=%b max=%0d min=%0d", k, fd, ff, pmax, pmin, e.d, e.f, e.mx, e.mn);
      end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    exp_t e;
    @(negedge clk);
    tests++;
    if (fd !== 8'd42) begin
      fails++;
      $display("FAIL pre_reset_data: data=%0d, expected 42", fd);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({fv, fd, ff, pmax, pmin} !== {1'b0, 8'd0, 1'b0, 8'd0, 8'hff}) begin
      fails++;
      $display("FAIL async_reset: vld=%b data=%0d full=%b max=%0d min=%0d, expected 0 0 0 0 255", fv, fd, ff, pmax, pmin);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    last = cyc;
    for (int k = 1; k <= 2; k++) begin
      adc = 8'd100;
      push_exp(adc, k == 1 ? 8'd12 : 8'd25);
      wait_vld(ok);
      e = sb.pop_front();
      tests++;
      if (!ok || {fd, ff, pmax, pmin} !== {e.d, e.f, e.mx, e.mn}) begin
        fails++;
        $display("FAIL post_reset[%0d]: vld=%b data=%0d full=%b max=%0d min=%0d, expected data=%0d full=%b max=%0d min=%0d", k, ok, fd, ff, pmax, pmin, e.d, e.f, e.mx, e.mn);
      end
      tests++;
      if (cyc - last != DV) begin
        fails++;
        $display("FAIL post_reset_spacing[%0d]: %0d cycles, expected %0d", k, cyc - last, DV);
      end
      last = cyc;
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_full_scale();
    test_step_down();
    test_clear_collision();
    test_peak();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
